// File: rtl/tbird_pkg.sv
// Shared types for the T-bird tail-light FSM and its bus observer.
// Lamp patterns, the light-FSM state type, decoder states and the pattern classifier.
package tbird_pkg;

  typedef enum logic [2:0] {
    LS_IDLE, LS_L1, LS_L2, LS_L3, LS_R1, LS_R2, LS_R3, LS_LR3
  } t_tbird_lights_state;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_1   = 3'b001;
  localparam logic [2:0] LAMP_2   = 3'b011;
  localparam logic [2:0] LAMP_3   = 3'b111;

  // The first eight decoder states share their ordering with t_tbird_lights_state.
  typedef enum logic [3:0] {
    D_IDLE, D_L1, D_L2, D_L3, D_R1, D_R2, D_R3, D_LR3, D_SYNC
  } t_tbird_dec_state;

  typedef struct packed {
    logic                legal;
    t_tbird_lights_state pat;
  } t_tbird_class;

  function automatic t_tbird_class tbird_classify(input logic [2:0] l, input logic [2:0] r);
    t_tbird_class c;
    c.legal = 1'b1;
    c.pat   = LS_IDLE;
    case ({l, r})
      {LAMP_OFF, LAMP_OFF}: c.pat = LS_IDLE;
      {LAMP_1,   LAMP_OFF}: c.pat = LS_L1;
      {LAMP_2,   LAMP_OFF}: c.pat = LS_L2;
      {LAMP_3,   LAMP_OFF}: c.pat = LS_L3;
      {LAMP_OFF, LAMP_1  }: c.pat = LS_R1;
      {LAMP_OFF, LAMP_2  }: c.pat = LS_R2;
      {LAMP_OFF, LAMP_3  }: c.pat = LS_R3;
      {LAMP_3,   LAMP_3  }: c.pat = LS_LR3;
      default:              c.legal = 1'b0;
    endcase
    return c;
  endfunction

  function automatic t_tbird_dec_state tbird_to_dec(input t_tbird_lights_state p);
    return t_tbird_dec_state'({1'b0, p});
  endfunction

endpackage

// File: rtl/tbird_light_decoder_if.sv
// Lamp bus plus decoder status/counter outputs for the T-bird light observer.
interface tbird_light_decoder_if #(parameter int CNT_W = 8);
  logic [2:0]       l_lights;
  logic [2:0]       r_lights;
  logic             clr;
  logic             left_done;
  logic             right_done;
  logic             haz_done;
  logic             haz_abort;
  logic             err;
  logic             in_sync;
  logic [CNT_W-1:0] left_cnt;
  logic [CNT_W-1:0] right_cnt;
  logic [CNT_W-1:0] haz_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output l_lights, r_lights, clr,
    input  left_done, right_done, haz_done, haz_abort, err, in_sync,
    input  left_cnt, right_cnt, haz_cnt, err_cnt
  );

  modport slave (
    input  l_lights, r_lights, clr,
    output left_done, right_done, haz_done, haz_abort, err, in_sync,
    output left_cnt, right_cnt, haz_cnt, err_cnt
  );
endinterface

// File: rtl/tbird_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module tbird_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_b || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tbird_light_decoder.sv
// Observer for the T-bird tail-light bus: tracks the legal lamp sequence,
// pulses on completed/aborted sequences and errors, and counts events.
module tbird_light_decoder
  import tbird_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int MAX_HOLD = 1
) (
  input logic                   clk,
  input logic                   rst_b,
  tbird_light_decoder_if.slave  bus
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  t_tbird_dec_state  state, state_nxt, pat_d;
  t_tbird_class      cls;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              left_q, right_q, haz_q, abort_q, err_q, in_sync_q;
  logic              left_nxt, right_nxt, haz_nxt, abort_nxt, err_nxt;
  logic              step_ok, in_seq;

  always_comb begin
    cls       = tbird_classify(bus.l_lights, bus.r_lights);
    pat_d     = tbird_to_dec(cls.pat);
    state_nxt = state;
    hold_nxt  = '0;
    left_nxt  = 1'b0;
    right_nxt = 1'b0;
    haz_nxt   = 1'b0;
    abort_nxt = 1'b0;
    err_nxt   = 1'b0;
    step_ok   = 1'b0;
    in_seq    = (state == D_L1) || (state == D_L2) || (state == D_R1) || (state == D_R2);

    if (state == D_SYNC) begin
      if (cls.legal && cls.pat == LS_IDLE) state_nxt = D_IDLE;
    end else if (!cls.legal) begin
      err_nxt = 1'b1;
    end else if (pat_d == state) begin
      // Repeating IDLE is free; a repeated lamp pattern consumes hold budget.
      if (state != D_IDLE) begin
        if (int'(hold_cnt) + 1 < MAX_HOLD) hold_nxt = hold_cnt + HOLD_W'(1);
        else err_nxt = 1'b1;
      end
    end else begin
      case (state)
        D_IDLE:                step_ok = (pat_d == D_L1) || (pat_d == D_R1) || (pat_d == D_LR3);
        D_L1:                  step_ok = (pat_d == D_L2) || (pat_d == D_LR3);
        D_L2:                  step_ok = (pat_d == D_L3) || (pat_d == D_LR3);
        D_R1:                  step_ok = (pat_d == D_R2) || (pat_d == D_LR3);
        D_R2:                  step_ok = (pat_d == D_R3) || (pat_d == D_LR3);
        D_L3, D_R3, D_LR3:     step_ok = (pat_d == D_IDLE);
        default:               step_ok = 1'b0;
      endcase
      if (step_ok) begin
        state_nxt = pat_d;
        left_nxt  = (pat_d == D_L3);
        right_nxt = (pat_d == D_R3);
        haz_nxt   = (pat_d == D_LR3);
        abort_nxt = (pat_d == D_LR3) && in_seq;
      end else begin
        err_nxt = 1'b1;
      end
    end

    if (err_nxt) begin
      hold_nxt  = '0;
      state_nxt = (cls.pat == LS_IDLE && cls.legal) ? D_IDLE : D_SYNC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= D_IDLE;
      hold_cnt  <= '0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      haz_q     <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
      in_sync_q <= 1'b1;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      left_q    <= left_nxt;
      right_q   <= right_nxt;
      haz_q     <= haz_nxt;
      abort_q   <= abort_nxt;
      err_q     <= err_nxt;
      in_sync_q <= (state_nxt != D_SYNC);
    end
  end

  assign bus.left_done  = left_q;
  assign bus.right_done = right_q;
  assign bus.haz_done   = haz_q;
  assign bus.haz_abort  = abort_q;
  assign bus.err        = err_q;
  assign bus.in_sync    = in_sync_q;

  // Counters take the next-cycle pulses so each count lands with its pulse.
  tbird_sat_counter #(.CNT_W(CNT_W)) u_left_cnt (
    .clk(clk), .rst_b(rst_b), .inc(left_nxt), .clr(bus.clr), .cnt(bus.left_cnt)
  );
  tbird_sat_counter #(.CNT_W(CNT_W)) u_right_cnt (
    .clk(clk), .rst_b(rst_b), .inc(right_nxt), .clr(bus.clr), .cnt(bus.right_cnt)
  );
  tbird_sat_counter #(.CNT_W(CNT_W)) u_haz_cnt (
    .clk(clk), .rst_b(rst_b), .inc(haz_nxt), .clr(bus.clr), .cnt(bus.haz_cnt)
  );
  tbird_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk(clk), .rst_b(rst_b), .inc(err_nxt), .clr(bus.clr), .cnt(bus.err_cnt)
  );

endmodule

// File: tb/tb_tbird_light_decoder.sv
// Self-checking bench for tbird_light_decoder: lamp-count reference model checked
// every cycle, plus hand-computed expectations after each directed scenario.
module tb_tbird_light_decoder;

  localparam int CNT_W    = 2;
  localparam int MAX_HOLD = 1;
  localparam int CMAX     = (1 << CNT_W) - 1;

  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] ON1 = 3'b001;
  localparam logic [2:0] ON2 = 3'b011;
  localparam logic [2:0] ON3 = 3'b111;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;

  tbird_light_decoder_if #(.CNT_W(CNT_W)) bus ();

  tbird_light_decoder #(.CNT_W(CNT_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  bit m_sync = 1'b1;
  int m_l = 0, m_r = 0, m_run = 1;
  bit e_left, e_right, e_haz, e_abort, e_err;
  bit e_sync = 1'b1;
  int e_lc = 0, e_rc = 0, e_hc = 0, e_ec = 0;

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] l, input logic [2:0] r,
                               input logic c, input logic rb);
    bus.l_lights = l;
    bus.r_lights = r;
    bus.clr      = c;
    rst_b        = rb;
    @(posedge clk);
    #1;
  endtask

  function automatic int satAdd(input int v, input bit inc);
    return (inc && v < CMAX) ? v + 1 : v;
  endfunction

  // Reference model: lamps as lit counts per side; a step is legal if it adds one lamp
  // to a single-sided sequence, jumps to both-full from IDLE or mid-sequence, or clears a full pattern.
  initial forever begin
    int ln, rn;
    bit legal, idle, ok, fault;
    @(posedge clk);
    {e_left, e_right, e_haz, e_abort, e_err} = '0;
    if (!rst_b) begin
      m_sync = 1'b1; m_l = 0; m_r = 0; m_run = 1;
      e_sync = 1'b1; e_lc = 0; e_rc = 0; e_hc = 0; e_ec = 0;
    end else begin
      ln    = $countones(bus.l_lights);
      rn    = $countones(bus.r_lights);
      legal = (bus.l_lights == 3'((1 << ln) - 1)) && (bus.r_lights == 3'((1 << rn) - 1)) &&
              (ln == 0 || rn == 0 || (ln == 3 && rn == 3));
      idle  = legal && ln == 0 && rn == 0;
      fault = 1'b0;
      ok    = 1'b0;
      if (!m_sync) begin
        if (idle) begin m_sync = 1'b1; m_l = 0; m_r = 0; m_run = 1; end
      end else if (!legal) begin
        fault = 1'b1;
      end else if (ln == m_l && rn == m_r) begin
        if (!idle) begin
          if (m_run + 1 <= MAX_HOLD) m_run++;
          else fault = 1'b1;
        end
      end else begin
        if (m_l == 3 || m_r == 3)      ok = idle;
        else if (m_l == 0 && m_r == 0) ok = (ln + rn == 1) || (ln == 3 && rn == 3);
        else ok = (ln == 3 && rn == 3) || (m_r == 0 && rn == 0 && ln == m_l + 1) ||
                  (m_l == 0 && ln == 0 && rn == m_r + 1);
        if (ok) begin
          e_left  = (ln == 3 && rn == 0);
          e_right = (ln == 0 && rn == 3);
          e_haz   = (ln == 3 && rn == 3);
          e_abort = e_haz && !(m_l == 0 && m_r == 0);
          m_l = ln; m_r = rn; m_run = 1;
        end else begin
          fault = 1'b1;
        end
      end
      if (fault) begin
        e_err = 1'b1;
        if (idle) begin m_l = 0; m_r = 0; m_run = 1; end
        else m_sync = 1'b0;
      end
      e_sync = m_sync;
      if (bus.clr) begin
        e_lc = 0; e_rc = 0; e_hc = 0; e_ec = 0;
      end else begin
        e_lc = satAdd(e_lc, e_left);
        e_rc = satAdd(e_rc, e_right);
        e_hc = satAdd(e_hc, e_haz);
        e_ec = satAdd(e_ec, e_err);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      checkOutput("left_done",  8'(bus.left_done),  8'(e_left));
      checkOutput("right_done", 8'(bus.right_done), 8'(e_right));
      checkOutput("haz_done",   8'(bus.haz_done),   8'(e_haz));
      checkOutput("haz_abort",  8'(bus.haz_abort),  8'(e_abort));
      checkOutput("err",        8'(bus.err),        8'(e_err));
      checkOutput("in_sync",    8'(bus.in_sync),    8'(e_sync));
      checkOutput("left_cnt",   8'(bus.left_cnt),   8'(e_lc));
      checkOutput("right_cnt",  8'(bus.right_cnt),  8'(e_rc));
      checkOutput("haz_cnt",    8'(bus.haz_cnt),    8'(e_hc));
      checkOutput("err_cnt",    8'(bus.err_cnt),    8'(e_ec));
    end
  end

  initial begin
    bus.l_lights = OFF;
    bus.r_lights = OFF;
    bus.clr      = 1'b0;
    applyStimulus(OFF, OFF, 1'b0, 1'b0);
    applyStimulus(OFF, OFF, 1'b0, 1'b0);
    chk_en = 1'b1;
    checkOutput("rst_in_sync", 8'(bus.in_sync), 8'd1);
    checkOutput("rst_err",     8'(bus.err),     8'd0);
    checkOutput("rst_haz_cnt", 8'(bus.haz_cnt), 8'd0);

    $display("[TB] left sequence");
    applyStimulus(OFF, OFF, 1'b0, 1'b1);
    applyStimulus(ON1, OFF, 1'b0, 1'b1);
    applyStimulus(ON2, OFF, 1'b0, 1'b1);
    applyStimulus(ON3, OFF, 1'b0, 1'b1);
    checkOutput("t1_left_done", 8'(bus.left_done), 8'd1);
    checkOutput("t1_left_cnt",  8'(bus.left_cnt),  8'd1);
    applyStimulus(OFF, OFF, 1'b0, 1'b1);
    checkOutput("t1_left_done_low", 8'(bus.left_done), 8'd0);

    $display("[TB] hazard abort");
    applyStimulus(OFF, ON1, 1'b0, 1'b1);
    applyStimulus(ON3, ON3, 1'b0, 1'b1);
    checkOutput("t2_haz_done",  8'(bus.haz_done),  8'd1);
    checkOutput("t2_haz_abort", 8'(bus.haz_abort), 8'd1);
    checkOutput("t2_haz_cnt",   8'(bus.haz_cnt),   8'd1);
    checkOutput("t2_right_cnt", 8'(bus.right_cnt), 8'd0);
    applyStimulus(OFF, OFF, 1'b0, 1'b1);

    $display("[TB] hold overrun");
    applyStimulus(ON1, OFF, 1'b0, 1'b1);
    applyStimulus(ON1, OFF, 1'b0, 1'b1);
    checkOutput("t3_err",     8'(bus.err),     8'd1);
    checkOutput("t3_in_sync", 8'(bus.in_sync), 8'd0);
    applyStimulus(OFF, OFF, 1'b0, 1'b1);
    checkOutput("t3_resync",  8'(bus.in_sync), 8'd1);

    $display("[TB] illegal pattern");
    applyStimulus(3'b010, OFF, 1'b0, 1'b1);
    checkOutput("t4_err",      8'(bus.err),     8'd1);
    checkOutput("t4_err_cnt",  8'(bus.err_cnt), 8'd2);
    applyStimulus(ON2, OFF, 1'b0, 1'b1);
    checkOutput("t4_sync_quiet", 8'(bus.err),   8'd0);
    applyStimulus(OFF, OFF, 1'b0, 1'b1);
    checkOutput("t4_resync", 8'(bus.in_sync), 8'd1);

    $display("[TB] hazard saturation and clear");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(ON3, ON3, 1'b0, 1'b1);
      checkOutput("t5_haz_done",  8'(bus.haz_done),  8'd1);
      checkOutput("t5_haz_abort", 8'(bus.haz_abort), 8'd0);
      applyStimulus(OFF, OFF, 1'b0, 1'b1);
    end
    checkOutput("t5_haz_sat", 8'(bus.haz_cnt), 8'd3);
    applyStimulus(ON3, ON3, 1'b1, 1'b1);
    checkOutput("t5_clr_pulse", 8'(bus.haz_done), 8'd1);
    checkOutput("t5_clr_cnt",   8'(bus.haz_cnt),  8'd0);
    checkOutput("t5_clr_err",   8'(bus.err_cnt),  8'd0);
    applyStimulus(OFF, OFF, 1'b0, 1'b1);

    $display("[TB] right sequence, hold and early idle");
    applyStimulus(OFF, ON1, 1'b0, 1'b1);
    applyStimulus(OFF, ON2, 1'b0, 1'b1);
    applyStimulus(OFF, ON3, 1'b0, 1'b1);
    checkOutput("rs_right_done", 8'(bus.right_done), 8'd1);
    checkOutput("rs_right_cnt",  8'(bus.right_cnt),  8'd1);
    applyStimulus(OFF, ON3, 1'b0, 1'b1);
    checkOutput("rs_hold_err", 8'(bus.err), 8'd1);
    applyStimulus(OFF, OFF, 1'b0, 1'b1);
    applyStimulus(ON1, OFF, 1'b0, 1'b1);
    applyStimulus(OFF, OFF, 1'b0, 1'b1);
    checkOutput("ei_err",     8'(bus.err),     8'd1);
    checkOutput("ei_in_sync", 8'(bus.in_sync), 8'd1);
    for (int i = 0; i < 3; i++) applyStimulus(OFF, OFF, 1'b0, 1'b1);

    $display("[TB] reset mid-sequence");
    applyStimulus(ON1, OFF, 1'b0, 1'b1);
    applyStimulus(ON2, OFF, 1'b0, 1'b0);
    checkOutput("t6_in_sync",   8'(bus.in_sync),   8'd1);
    checkOutput("t6_err",       8'(bus.err),       8'd0);
    checkOutput("t6_right_cnt", 8'(bus.right_cnt), 8'd0);
    applyStimulus(ON3, OFF, 1'b0, 1'b1);
    checkOutput("t6_err_after", 8'(bus.err),       8'd1);
    checkOutput("t6_left_done", 8'(bus.left_done), 8'd0);
    applyStimulus(OFF, OFF, 1'b0, 1'b1);
    checkOutput("t6_resync", 8'(bus.in_sync), 8'd1);
    applyStimulus(OFF, OFF, 1'b0, 1'b1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
